// File: rtl/deser400_gate_ctrl_pkg.sv
// Shared types and constants for the deser400 measurement-gate scheduler.
// The DEF_* values are also used by the legacy free-running gate instantiation.
package deser400_pkg;

  localparam int CNT_W = 22;
  localparam int NUM_W = 16;

  // Period register holds period-1: 2^22 cycles per period, 2^19-cycle gate.
  localparam logic [CNT_W-1:0] DEF_PERIOD = 22'd4194303;
  localparam logic [CNT_W-1:0] DEF_LEN    = 22'd524288;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] len;
    logic             burst;
    logic [NUM_W-1:0] num;
  } cfg_t;

  typedef struct packed {
    state_t state;
    logic   pend_valid;
    cfg_t   active;
  } dbg_t;

  function automatic cfg_t def_cfg();
    cfg_t c;
    c.period = DEF_PERIOD;
    c.len    = DEF_LEN;
    c.burst  = 1'b0;
    c.num    = NUM_W'(1);
    return c;
  endfunction

  // A burst of zero periods is run as a single period.
  function automatic logic [NUM_W-1:0] burst_count(input logic [NUM_W-1:0] num);
    return (num == '0) ? NUM_W'(1) : num;
  endfunction

endpackage

// File: rtl/deser400_gate_ctrl_if.sv
// Control-register bank <-> gate scheduler connection.
// cfg_we, start and stop are single-cycle pulses with no ready/back-pressure;
// gate, busy, period_stb, done and periods are registered status outputs.
interface deser400_gate_ctrl_if;
  import deser400_pkg::*;

  logic             cfg_we;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_len;
  logic             cfg_burst;
  logic [NUM_W-1:0] cfg_num;
  logic             start;
  logic             stop;

  logic             gate;
  logic             busy;
  logic             period_stb;
  logic             done;
  logic [NUM_W-1:0] periods;

  modport master (
    output cfg_we, cfg_period, cfg_len, cfg_burst, cfg_num, start, stop,
    input  gate, busy, period_stb, done, periods
  );

  modport slave (
    input  cfg_we, cfg_period, cfg_len, cfg_burst, cfg_num, start, stop,
    output gate, busy, period_stb, done, periods
  );

endinterface

// File: rtl/deser400_gate_ctrl_cfg.sv
// Active/pending configuration shadow registers. Writes made while running are
// held in pending and swapped in only at a period boundary or on return to idle.
module deser400_gate_cfg
  import deser400_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  cfg_t             cfg_in,
  input  logic             running,
  input  logic             wrap,
  input  logic             go_idle,
  output cfg_t             active,
  output logic [CNT_W-1:0] nxt_len,
  output logic [NUM_W-1:0] nxt_num,
  output logic             pend_valid
);

  cfg_t pending;
  cfg_t active_nxt;
  logic apply;

  always_comb begin
    active_nxt = active;
    apply      = running && pend_valid && (wrap || go_idle);
    // A write on the cycle the run ends is newer than anything pending.
    if (cfg_we && (!running || go_idle)) begin
      active_nxt = cfg_in;
    end else if (apply) begin
      active_nxt = pending;
    end
  end

  assign nxt_len = active_nxt.len;
  assign nxt_num = active_nxt.num;

  always_ff @(posedge clk) begin
    if (reset) begin
      active     <= def_cfg();
      pending    <= def_cfg();
      pend_valid <= 1'b0;
    end else begin
      active <= active_nxt;
      if (running && !go_idle && cfg_we) begin
        pending    <= cfg_in;
        pend_valid <= 1'b1;
      end else if (apply || go_idle) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/deser400_gate_ctrl.sv
// Programmable period/gate-length scheduler driving the deser400 gate input,
// with continuous or N-period burst operation and boundary-safe reconfiguration.
module deser400_gate_ctrl
  import deser400_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  deser400_gate_ctrl_if.slave  bus,
  output dbg_t                 dbg
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NUM_W-1:0] remain_q, remain_d;
  logic [NUM_W-1:0] periods_q, periods_d;
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             stb_q, stb_d;
  logic             done_q, done_d;

  cfg_t             cfg_in;
  cfg_t             act;
  logic [CNT_W-1:0] nxt_len;
  logic [NUM_W-1:0] nxt_num;
  logic             pend_valid;

  logic running, at_end, burst_last, to_idle, launch;

  assign cfg_in = '{period: bus.cfg_period, len: bus.cfg_len,
                    burst: bus.cfg_burst, num: bus.cfg_num};

  assign running    = (state_q == RUN);
  assign at_end     = running && (cnt_q == act.period);
  assign burst_last = at_end && act.burst && (remain_q == NUM_W'(1));
  assign to_idle    = running && (bus.stop || burst_last);
  assign launch     = (state_q == IDLE) && bus.start && !bus.stop;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  deser400_gate_cfg u_cfg (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (bus.cfg_we),
    .cfg_in     (cfg_in),
    .running    (running),
    .wrap       (at_end),
    .go_idle    (to_idle),
    .active     (act),
    .nxt_len    (nxt_len),
    .nxt_num    (nxt_num),
    .pend_valid (pend_valid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    remain_d  = remain_q;
    periods_d = periods_q;
    gate_d    = 1'b0;
    busy_d    = 1'b0;
    stb_d     = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d   = RUN;
          cnt_d     = '0;
          periods_d = '0;
          remain_d  = burst_count(nxt_num);
          gate_d    = (nxt_len != '0);
          busy_d    = 1'b1;
          stb_d     = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (at_end) begin
          cnt_d     = '0;
          periods_d = periods_q + NUM_W'(1);
          if (burst_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // The new period already runs with any config swapped in at this wrap.
            busy_d = 1'b1;
            stb_d  = 1'b1;
            gate_d = (nxt_len != '0);
            if (act.burst) remain_d = remain_q - NUM_W'(1);
          end
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_inc;
          gate_d = (cnt_inc < act.len);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      remain_q  <= '0;
      periods_q <= '0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      stb_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      remain_q  <= remain_d;
      periods_q <= periods_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      stb_q     <= stb_d;
      done_q    <= done_d;
    end
  end

  assign bus.gate       = gate_q;
  assign bus.busy       = busy_q;
  assign bus.period_stb = stb_q;
  assign bus.done       = done_q;
  assign bus.periods    = periods_q;

  assign dbg.state      = state_q;
  assign dbg.pend_valid = pend_valid;
  assign dbg.active     = act;

endmodule
